// File: rtl/seq_divider_pkg.sv
// Shared widths, constants and FSM state type for the sequential divider.
package seq_divider_pkg;

  localparam int unsigned DW_N_DEF = 24;
  localparam int unsigned DW_D_DEF = 12;
  localparam int unsigned KYBER_Q  = 3329;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned DW_D = 12
) (
  input  logic [DW_D:0]   rem_in,
  input  logic            bit_in,
  input  logic [DW_D-1:0] divisor,
  output logic [DW_D:0]   rem_out,
  output logic            q_bit
);

  logic [DW_D+1:0] shifted;

  // One extra bit above the partial remainder keeps the compare exact even when divisor is zero
  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= {2'b00, divisor});
  assign rem_out = (DW_D+1)'(q_bit ? shifted - {2'b00, divisor} : shifted);

endmodule

// File: rtl/seq_divider.sv
// Fixed-latency restoring divider: DW_N BUSY cycles per operation, valid/ready handshakes.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned DW_N = DW_N_DEF,
  parameter int unsigned DW_D = DW_D_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW_N-1:0] dividend,
  input  logic [DW_D-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW_N-1:0] quotient,
  output logic [DW_D-1:0] remainder,
  output logic            div_by_zero
);

  localparam int unsigned CW = (DW_N > 1) ? $clog2(DW_N) : 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [DW_N-1:0] dvd_q;
  logic [DW_D-1:0] dvs_q;
  logic [DW_D:0]   rem_q;
  logic [DW_D:0]   rem_next;
  logic            q_bit;

  div_step #(.DW_D(DW_D)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[DW_N-1]),
    .divisor (dvs_q),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // dvd_q doubles as the quotient accumulator: dividend bits leave at the MSB as quotient bits enter at the LSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
            cnt   <= CW'(DW_N - 1);
            state <= BUSY;
          end
        end
        BUSY: begin
          rem_q <= rem_next;
          dvd_q <= {dvd_q[DW_N-2:0], q_bit};
          if (cnt == '0) begin
            quotient    <= {dvd_q[DW_N-2:0], q_bit};
            remainder   <= rem_next[DW_D-1:0];
            div_by_zero <= (dvs_q == '0);
            state       <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DW_N, default 24, meaning dividend and quotient width.
REQ-002 SHALL have parameter DW_D, default 12, meaning divisor and remainder width (Kyber coefficient width).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port dividend  input  DW_N  unsigned numerator.
REQ-008 SHALL have port divisor  input  DW_D  unsigned denominator.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port quotient  output  DW_N  unsigned quotient.
REQ-012 SHALL have port remainder  output  DW_D  unsigned remainder.
REQ-013 SHALL have port div_by_zero  output  1  divisor was zero for the current result.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE: an edge with in_valid=1 accepts and registers the operands, loads step counter with DW_N-1, clears the partial remainder, and moves to BUSY.
REQ-017 BUSY: each edge performs one restoring radix-2 step: shift partial remainder left one bit, inserting the next dividend MSB; if the result is >= divisor, subtract and shift in quotient bit 1, else shift in 0.
REQ-018 Partial remainder SHALL be DW_D+1 bits wide internally, so the trial subtraction never overflows.
REQ-019 BUSY SHALL last exactly DW_N edges; after the edge where the counter is 0, the FSM SHALL move to DONE.
REQ-020 out_valid SHALL rise after the 24th rising edge following the accepting edge (default widths); latency is fixed and independent of operand values.
REQ-021 DONE: quotient, remainder, and div_by_zero SHALL be held stable until an edge with out_ready=1, which moves the FSM to IDLE.
REQ-022 An operation SHALL never be accepted in the same cycle as a result is consumed; minimum issue interval is DW_N+2 cycles.
REQ-023 in_valid in BUSY or DONE SHALL be ignored, with no effect on state.
REQ-024 out_ready outside DONE SHALL be ignored.
REQ-025 For divisor=0, the block SHALL still take DW_N BUSY cycles, then output quotient all ones, remainder dividend[DW_D-1:0], and div_by_zero=1; otherwise div_by_zero=0.
REQ-026 For dividend < divisor, the block SHALL give quotient=0 and remainder=dividend.
REQ-027 Results SHALL satisfy quotient*divisor + remainder = dividend, with remainder < divisor, for every non-zero divisor.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, and clear the counter and partial remainder.
REQ-029 Reset asserted during BUSY or DONE SHALL discard the operation; no result is produced after release.
REQ-030 After rst_n deasserts, the first rising edge SHALL be able to accept an operation.

Structure
REQ-031 Package seq_divider_pkg SHALL hold DW_N/DW_D defaults, KYBER_Q=3329, and the FSM state typedef.
REQ-032 The single restoring step SHALL be a combinational sub-module div_step (inputs: partial remainder, next bit, divisor; outputs: new partial remainder, quotient bit), instantiated once.

Verification
REQ-033 The bench SHALL cover: dividend=100, divisor=7 -> quotient=14, remainder=2, div_by_zero=0, out_valid 24 edges after accept.
REQ-034 The bench SHALL cover: Kyber compress, dividend=17664, divisor=3329 -> quotient=5, remainder=1019.
REQ-035 The bench SHALL cover: dividend=0xFFFFFF, divisor=0xFFF -> quotient=4097, remainder=0; dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-036 The bench SHALL cover: dividend=12345, divisor=0 -> quotient=0xFFFFFF, remainder=0x039, div_by_zero=1, same latency.
REQ-037 The bench SHALL cover: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, and a new in_valid is ignored; after out_ready=1 -> IDLE next cycle.
REQ-038 The bench SHALL cover: rst_n pulsed low at BUSY step 10 -> out_valid=0 immediately and stays 0; a fresh 100/7 gives correct 14/2.
